// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, responder states and JEDEC byte selection shared by the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_RDSR      = 8'h05;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RDID      = 8'h9F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_t;

    // RDID streams the three ID bytes MSB first, then zeros forever
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        return idx == 2'd0 ? id[23:16] : idx == 2'd1 ? id[15:8] : idx == 2'd2 ? id[7:0] : 8'h00;
    endfunction

endpackage

// File: rtl/spi_resp_sync.sv
// spi_resp_sync: 2-flop synchronizers for sclk/cs_n/mosi plus edge detection on the synchronized sclk and cs_n.
module spi_resp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_n_s,
    output logic mosi_s
);

    logic [1:0] sclk_ff, cs_ff, mosi_ff, live;
    logic       sclk_q, cs_q;

    // cs_q only becomes 1 from a real post-reset sample, so a chip select
    // already low at reset release never produces a falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_ff <= 2'b00;
            cs_ff   <= 2'b11;
            mosi_ff <= 2'b00;
            live    <= 2'b00;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b0;
        end else begin
            sclk_ff <= {sclk_ff[0], sclk};
            cs_ff   <= {cs_ff[0], cs_n};
            mosi_ff <= {mosi_ff[0], mosi};
            live    <= {live[0], 1'b1};
            sclk_q  <= sclk_ff[1];
            cs_q    <= cs_ff[1] & live[1];
        end
    end

    assign sclk_rise = sclk_ff[1] & ~sclk_q;
    assign sclk_fall = ~sclk_ff[1] & sclk_q;
    assign cs_fall   = cs_q & ~cs_ff[1];
    assign cs_n_s    = cs_ff[1];
    assign mosi_s    = mosi_ff[1];

endmodule

// File: rtl/spi_flash_resp.sv
// spi_flash_resp: SPI mode-0 serial-flash responder (READ, RDID, RDSR) over a byte-wide memory read port.
// Define SPI_FLASH_RESP_FAST_READ_EN to also accept FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_resp
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [23:0] JEDEC_ID   = 24'h012018
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic                  o_miso_oe,
    output logic                  o_mem_rd,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [7:0]            i_mem_rdata,
    output logic                  o_cmd_err
);

    state_t     state, state_nxt;
    logic       sclk_rise, sclk_fall, cs_fall, cs_n_s, mosi_s;
    logic       rise, fall, rd_op, fast, start, rd_d;
    logic [7:0] shreg, op_in, tx, nxt;
    logic [4:0] cnt;
    logic [2:0] tcnt;
    logic [1:0] idb;

    spi_resp_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (i_sclk),
        .cs_n      (i_cs_n),
        .mosi      (i_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s)
    );

    // a chip-select edge in the same clk masks any sclk edge
    assign rise  = sclk_rise & ~cs_n_s & ~cs_fall;
    assign fall  = sclk_fall & ~cs_n_s & ~cs_fall;
    assign op_in = {shreg[6:0], mosi_s};
    assign start = state_nxt == ST_DATA && state != ST_DATA;

`ifdef SPI_FLASH_RESP_FAST_READ_EN
    assign fast  = shreg == OP_FAST_READ;
    assign rd_op = op_in == OP_READ || op_in == OP_FAST_READ;
`else
    assign fast  = 1'b0;
    assign rd_op = op_in == OP_READ;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_n_s)
            state_nxt = ST_IDLE;
        else if (cs_fall)
            state_nxt = ST_CMD;
        else if (rise) begin
            if (state == ST_CMD && cnt == 5'd7)
                state_nxt = (op_in == OP_RDID || op_in == OP_RDSR) ? ST_DATA : rd_op ? ST_ADDR : ST_IGNORE;
            else if (state == ST_ADDR && cnt == 5'd23)
                state_nxt = fast ? ST_DUMMY : ST_DATA;
            else if (state == ST_DUMMY && cnt == 5'd7)
                state_nxt = ST_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_miso     <= 1'b0;
            o_miso_oe  <= 1'b0;
            o_mem_rd   <= 1'b0;
            o_mem_addr <= '0;
            o_cmd_err  <= 1'b0;
            rd_d       <= 1'b0;
            shreg      <= 8'h00;
            tx         <= 8'h00;
            nxt        <= 8'h00;
            cnt        <= 5'd0;
            tcnt       <= 3'd0;
            idb        <= 2'd0;
        end else begin
            o_mem_rd  <= 1'b0;
            o_cmd_err <= state == ST_CMD && state_nxt == ST_IGNORE;
            rd_d      <= o_mem_rd;
            if (rd_d)
                nxt <= i_mem_rdata;
            if (cs_n_s) begin
                o_miso    <= 1'b0;
                o_miso_oe <= 1'b0;
            end
            if (state_nxt != state)
                cnt <= 5'd0;
            else if (rise)
                cnt <= cnt + 5'd1;
            if (rise && state == ST_CMD)
                shreg <= op_in;
            if (rise && state == ST_ADDR)
                o_mem_addr <= {o_mem_addr[ADDR_WIDTH-2:0], mosi_s};
            if (start) begin
                tcnt <= 3'd0;
                idb  <= 2'd1;
                nxt  <= (state == ST_CMD && op_in == OP_RDID) ? id_byte(JEDEC_ID, 2'd0) : 8'h00;
                if (state != ST_CMD)
                    o_mem_rd <= 1'b1;
            end
            // the MSB of a byte comes from nxt; the next byte is fetched while its LSB goes out
            if (fall && state == ST_DATA) begin
                o_miso_oe <= 1'b1;
                o_miso    <= tcnt == 3'd0 ? nxt[7] : tx[7];
                tx        <= tcnt == 3'd0 ? {nxt[6:0], 1'b0} : {tx[6:0], 1'b0};
                tcnt      <= tcnt + 3'd1;
                if (tcnt == 3'd7) begin
                    if (shreg == OP_RDID) begin
                        nxt <= id_byte(JEDEC_ID, idb);
                        if (idb != 2'd3)
                            idb <= idb + 2'd1;
                    end else if (shreg != OP_RDSR) begin
                        o_mem_rd   <= 1'b1;
                        o_mem_addr <= o_mem_addr + ADDR_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_resp.sv
// tb_spi_flash_resp: mode-0 SPI host driving the responder against a byte memory, with a response-byte scoreboard.
module tb_spi_flash_resp;

    logic        clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic        miso, miso_oe, mem_rd, cmd_err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem [0:65535];
    logic [7:0]  txb [0:15];
    logic [7:0]  rxb [0:15];
    logic [7:0]  exp_q [$];
    logic [15:0] rd_log [$];
    int          err_cnt = 0, oe_cnt = 0;
    int          n_tests = 0, n_fail = 0;
    int          rd0 = 0, err0 = 0, oe0 = 0;

    always #5 clk = ~clk;

    spi_flash_resp #(.ADDR_WIDTH(16), .JEDEC_ID(24'h012018)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_sclk      (sclk),
        .i_cs_n      (cs_n),
        .i_mosi      (mosi),
        .o_miso      (miso),
        .o_miso_oe   (miso_oe),
        .o_mem_rd    (mem_rd),
        .o_mem_addr  (mem_addr),
        .i_mem_rdata (mem_rdata),
        .o_cmd_err   (cmd_err)
    );

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    always @(negedge clk) begin
        if (mem_rd) rd_log.push_back(mem_addr);
        if (cmd_err) err_cnt++;
        if (miso_oe) oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] rd_at(input int i);
        return (rd_log.size() > rd0 + i) ? 32'(rd_log[rd0 + i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic half();
        repeat (6) @(negedge clk);
    endtask

    task automatic load(input logic [31:0] hdr);
        for (int i = 0; i < 16; i++) begin
            txb[i] = 8'h00;
            rxb[i] = 8'h00;
        end
        txb[0] = hdr[31:24];
        txb[1] = hdr[23:16];
        txb[2] = hdr[15:8];
        txb[3] = hdr[7:0];
        rd0  = rd_log.size();
        err0 = err_cnt;
        oe0  = oe_cnt;
    endtask

    task automatic shift_bits(input int first, input int n);
        for (int b = first; b < first + n; b++) begin
            mosi = txb[b / 8][7 - b % 8];
            half();
            sclk = 1'b1;
            rxb[b / 8][7 - b % 8] = miso;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input int nbits);
        cs_n = 1'b0;
        half();
        shift_bits(0, nbits);
        half();
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("oe_off", miso_oe, 1'b0);
        repeat (8) @(negedge clk);
    endtask

    task automatic score(input int first);
        for (int i = first; exp_q.size() > 0; i++)
            check($sformatf("rx%0d", i), rxb[i], exp_q.pop_front());
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5C;
        mem[16'h0010] = 8'hA5; mem[16'h0011] = 8'h5A; mem[16'h0012] = 8'hC3; mem[16'h0013] = 8'h3C;
        mem[16'hFFFF] = 8'h77; mem[16'h0000] = 8'h11; mem[16'h0004] = 8'hE7;
        mem[16'h0020] = 8'h96; mem[16'h0021] = 8'h69;
        repeat (3) @(negedge clk);
        check("rst_miso", miso, 1'b0);
        check("rst_oe", miso_oe, 1'b0);
        check("rst_rd", mem_rd, 1'b0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_err", cmd_err, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        load(32'h03000010);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
        frame(64);
        score(4);
        for (int i = 0; i < 4; i++) check($sformatf("read_addr%0d", i), rd_at(i), 32'h10 + 32'(i));

        load(32'h9F000000);
        exp_q.push_back(8'h01); exp_q.push_back(8'h20); exp_q.push_back(8'h18);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        frame(48);
        score(1);
        check("rdid_rd_n", rd_log.size() - rd0, 0);

        load(32'h05000000);
        rxb[1] = 8'hFF;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        frame(24);
        score(1);
        check("rdsr_oe", oe_cnt > oe0, 1'b1);

        load(32'h0312FFFF);
        exp_q.push_back(8'h77); exp_q.push_back(8'h11);
        frame(48);
        score(4);
        check("wrap_addr0", rd_at(0), 32'hFFFF);
        check("wrap_addr1", rd_at(1), 32'h0000);

        load(32'h42000000);
        frame(32);
        check("bad_err_n", err_cnt - err0, 1);
        check("bad_oe", oe_cnt - oe0, 0);
        check("bad_rd_n", rd_log.size() - rd0, 0);

        load(32'h0B000004);
`ifdef SPI_FLASH_RESP_FAST_READ_EN
        exp_q.push_back(8'hE7);
        frame(48);
        score(5);
        check("fast_addr", rd_at(0), 32'h0004);
        check("fast_err_n", err_cnt - err0, 0);
`else
        frame(48);
        check("fast_err_n", err_cnt - err0, 1);
        check("fast_oe", oe_cnt - oe0, 0);
`endif

        load(32'h03000020);
        exp_q.push_back(8'h96);
        frame(44);
        score(4);
        check("abort_nibble", rxb[5][7:4], 4'h6);
        check("abort_rd_n", rd_log.size() - rd0, 2);
        load(32'h05000000);
        rxb[1] = 8'hFF;
        exp_q.push_back(8'h00);
        frame(16);
        score(1);

        load(32'h03000030);
        cs_n = 1'b0;
        half();
        shift_bits(0, 12);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_addr", mem_addr, 16'h0000);
        check("midrst_oe", miso_oe, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        shift_bits(12, 36);
        check("midrst_rd_n", rd_log.size() - rd0, 0);
        check("midrst_oe_n", oe_cnt - oe0, 0);
        check("midrst_err_n", err_cnt - err0, 0);
        half();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        load(32'h05000000);
        rxb[1] = 8'hFF;
        exp_q.push_back(8'h00);
        frame(16);
        score(1);
        check("post_rst_oe", oe_cnt > oe0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
